apb_requester: RTL and testbench

- APB4 requester (initiator) that turns single commands from an internal valid/ready command port into APB transfers on the PCLK domain.
- Completers such as the SFR blocks respond on the APB side; the result comes back on a valid/ready response port.
- One transfer in flight at a time.
- Inserts wait states on PREADY low and aborts with an error after a configurable timeout.

---
 rtl/apb_requester_if.sv | 45 ++++
 rtl/apb_requester.sv | 128 ++++++++++++
 tb/tb_apb_requester.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_if.sv
// Command/response port and APB4 bus joining the requester to its environment.
// master is the requester's view; slave is the command source plus APB completer.
interface apb_requester_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [STRB_WIDTH-1:0] cmd_strb;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  rsp_timeout;

   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [STRB_WIDTH-1:0] PSTRB;
   logic                  PREADY;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             PREADY, PRDATA, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             PREADY, PRDATA, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
   );
endinterface

// File: rtl/apb_requester.sv
// APB4 requester: one command at a time becomes an APB transfer; the result is
// returned on the response port, with a wait-state timeout that aborts with error.
module apb_requester #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic             PCLK,
   input logic             PRESETn,
   apb_requester_if.master bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TO_LAST_I  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_wait_cnt;
   logic                  r_cmd_ready;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  r_rsp_timeout;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic [STRB_WIDTH-1:0] r_pstrb;

   logic                  w_timeout_hit;

   assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == TO_LAST);

   // NOTE: state registers use non-blocking assignments so every register samples
   // pre-edge values; the asynchronous reset clears all outputs, dropping any transfer.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state       <= S_IDLE;
         r_wait_cnt    <= '0;
         r_cmd_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_paddr       <= '0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_pwdata      <= '0;
         r_pstrb       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // cmd_ready comes back one edge after reset release.
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_state     <= S_SETUP;
                  r_cmd_ready <= 1'b0;
                  r_wait_cnt  <= '0;
                  r_psel      <= 1'b1;
                  r_paddr     <= bus.cmd_addr;
                  r_pwrite    <= bus.cmd_write;
                  r_pwdata    <= bus.cmd_write ? bus.cmd_wdata : '0;
                  r_pstrb     <= bus.cmd_write ? bus.cmd_strb : '0;
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end

            S_SETUP: begin
               r_state   <= S_ACCESS;
               r_penable <= 1'b1;
            end

            S_ACCESS: begin
               if (bus.PREADY) begin
                  r_state       <= S_RESP;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_err     <= bus.PSLVERR;
                  r_rsp_timeout <= 1'b0;
                  r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
               end else if (w_timeout_hit) begin
                  r_state       <= S_RESP;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_err     <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  r_rsp_rdata   <= '0;
               end else if (r_wait_cnt != '1) begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end

            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready   = r_cmd_ready;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_rdata   = r_rsp_rdata;
   assign bus.rsp_err     = r_rsp_err;
   assign bus.rsp_timeout = r_rsp_timeout;
   assign bus.PADDR       = r_paddr;
   assign bus.PSEL        = r_psel;
   assign bus.PENABLE     = r_penable;
   assign bus.PWRITE      = r_pwrite;
   assign bus.PWDATA      = r_pwdata;
   assign bus.PSTRB       = r_pstrb;
endmodule

// File: tb/tb_apb_requester.sv
// Directed and randomized transfers through apb_requester, checked against a
// transaction-level model of the expected APB timing and response.
module tb_apb_requester;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   logic PCLK = 1'b0;
   logic PRESETn;

   always #5 PCLK = ~PCLK;

   apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // Completer plan: PREADY rises on ACCESS cycle index plan_waits (0-based).
   int            plan_waits = 0;
   logic [DW-1:0] plan_rdata = '0;
   logic          plan_err   = 1'b0;
   int            acc_idx    = 0;

   // Expected view of the transfer in flight.
   logic [AW-1:0] e_addr;
   logic          e_write;
   logic [DW-1:0] e_pw;
   logic [SW-1:0] e_ps;
   logic [DW-1:0] e_rdata;
   logic          e_err;
   logic          e_to;

   always @(negedge PCLK) begin
      if (bus.PSEL && bus.PENABLE) begin
         bus.PREADY  = (acc_idx == plan_waits);
         bus.PRDATA  = bus.PREADY ? plan_rdata : $urandom;
         bus.PSLVERR = bus.PREADY ? plan_err : 1'($urandom);
         acc_idx++;
      end else begin
         acc_idx     = 0;
         bus.PREADY  = 1'b0;
         bus.PRDATA  = $urandom;
         bus.PSLVERR = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for cmd_ready, presents the command and checks the SETUP cycle.
   task automatic issue(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
      int n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 50) begin
         @(negedge PCLK);
         n++;
      end
      check("cmd_ready_wait", 64'(n < 50), 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.cmd_strb  = strb;
      e_addr  = addr;
      e_write = wr;
      e_pw    = wr ? wdata : '0;
      e_ps    = wr ? strb : '0;
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
      check("setup_psel", bus.PSEL, 1);
      check("setup_penable", bus.PENABLE, 0);
      check("setup_paddr", bus.PADDR, e_addr);
      check("setup_pwrite", bus.PWRITE, e_write);
      check("setup_pwdata", bus.PWDATA, e_pw);
      check("setup_pstrb", bus.PSTRB, e_ps);
      check("setup_cmd_ready", bus.cmd_ready, 0);
   endtask

   // Runs the ACCESS phase; the model predicts its length and the response.
   task automatic access_phase(input int waits, input logic [DW-1:0] rdata, input logic slverr);
      int acc = 0;
      bit stable = 1'b1;
      bit exp_to;
      int exp_acc;
      exp_to  = (TO != 0) && (waits >= TO);
      exp_acc = exp_to ? TO : waits + 1;
      e_to    = exp_to;
      e_err   = exp_to ? 1'b1 : slverr;
      e_rdata = (exp_to || e_write) ? '0 : rdata;
      plan_waits = waits;
      plan_rdata = rdata;
      plan_err   = slverr;
      while (acc < 200) begin
         @(negedge PCLK);
         if (!(bus.PSEL && bus.PENABLE)) break;
         acc++;
         if (bus.PADDR !== e_addr || bus.PWRITE !== e_write || bus.PWDATA !== e_pw ||
             bus.PSTRB !== e_ps || bus.rsp_valid !== 1'b0) stable = 1'b0;
      end
      check("access_cycles", 64'(acc), 64'(exp_acc));
      check("access_apb_stable", 64'(stable), 1);
      check("resp_valid", bus.rsp_valid, 1);
      check("resp_psel", bus.PSEL, 0);
      check("resp_penable", bus.PENABLE, 0);
   endtask

   // Holds rsp_ready low for 'hold' cycles, then consumes the response.
   task automatic resp_phase(input int hold);
      bit ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e_rdata || bus.rsp_err !== e_err ||
             bus.rsp_timeout !== e_to || bus.cmd_ready !== 1'b0 || bus.PSEL !== 1'b0) ok = 1'b0;
         @(negedge PCLK);
      end
      check("rsp_hold_stable", 64'(ok), 1);
      check("rsp_rdata", bus.rsp_rdata, e_rdata);
      check("rsp_err", bus.rsp_err, e_err);
      check("rsp_timeout", bus.rsp_timeout, e_to);
      bus.rsp_ready = 1'b1;
      @(negedge PCLK);
      bus.rsp_ready = 1'b0;
      check("idle_rsp_valid", bus.rsp_valid, 0);
      check("idle_cmd_ready", bus.cmd_ready, 1);
      check("idle_psel", bus.PSEL, 0);
   endtask

   task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] strb, input int waits, input logic [DW-1:0] rdata,
                       input logic slverr, input int hold);
      issue(wr, addr, wdata, strb);
      access_phase(waits, rdata, slverr);
      resp_phase(hold);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_strb  = '0;
      bus.rsp_ready = 1'b0;
      PRESETn = 1'b0;

      // Reset values
      #12;
      check("rst_cmd_ready", bus.cmd_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_psel", bus.PSEL, 0);
      check("rst_penable", bus.PENABLE, 0);
      check("rst_paddr", bus.PADDR, 0);
      check("rst_pwdata", bus.PWDATA, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      check("post_rst_cmd_ready", bus.cmd_ready, 1);

      // 1: zero-wait write
      xfer(1'b1, 32'h0, 32'hA5A5_5A5A, 4'hF, 0, 32'h1111_2222, 1'b0, 0);
      // 2: read with three wait states
      xfer(1'b0, 32'h0, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 1'b0, 1);
      // 3: completer error on write
      xfer(1'b1, 32'h1, 32'h1234_5678, 4'h3, 0, 32'h0, 1'b1, 0);
      // 4: timeout, then PREADY on the last allowed cycle
      xfer(1'b0, 32'h40, 32'h0, 4'h0, 100, 32'hCAFE_F00D, 1'b0, 0);
      xfer(1'b0, 32'h44, 32'h0, 4'h0, TO - 1, 32'hCAFE_F00D, 1'b0, 0);
      check("paddr_held_idle", bus.PADDR, 32'h44);

      // 5: response backpressure with a second command waiting
      issue(1'b1, 32'h80, 32'h0BAD_F00D, 4'h5);
      access_phase(1, 32'h0, 1'b0);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h84;
      bus.cmd_wdata = 32'h0;
      bus.cmd_strb  = 4'h0;
      resp_phase(5);
      issue(1'b0, 32'h84, 32'h0, 4'h0);
      access_phase(0, 32'h5555_AAAA, 1'b0);
      resp_phase(0);

      // 6: reset during an ACCESS wait state
      issue(1'b0, 32'hC0, 32'h0, 4'h0);
      plan_waits = 100;
      @(negedge PCLK);
      @(negedge PCLK);
      #2 PRESETn = 1'b0;
      #1;
      check("arst_psel", bus.PSEL, 0);
      check("arst_penable", bus.PENABLE, 0);
      check("arst_rsp_valid", bus.rsp_valid, 0);
      check("arst_cmd_ready", bus.cmd_ready, 0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      begin
         bit stale = 1'b0;
         for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) stale = 1'b1;
         end
         check("arst_no_stale", 64'(stale), 0);
      end
      check("arst_cmd_ready_back", bus.cmd_ready, 1);
      xfer(1'b0, 32'hC4, 32'h0, 4'h0, 2, 32'h7777_8888, 1'b0, 0);

      // Randomized transfers
      for (int t = 0; t < 24; t++) begin
         logic          wr;
         logic [AW-1:0] addr;
         logic [DW-1:0] wd;
         logic [DW-1:0] rd;
         logic [SW-1:0] st;
         logic          er;
         int            w;
         int            gap;
         wr   = 1'($urandom);
         addr = $urandom;
         wd   = $urandom;
         rd   = $urandom;
         st   = SW'($urandom);
         er   = ($urandom_range(3) == 0);
         case ($urandom_range(7))
            0:       w = TO - 1 + $urandom_range(2);
            default: w = $urandom_range(5);
         endcase
         gap = $urandom_range(2);
         for (int g = 0; g < gap; g++) @(negedge PCLK);
         xfer(wr, addr, wd, st, w, rd, er, $urandom_range(3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
